// File: rtl/runway_scheduler_pkg.sv
// Shared BobATC types for the runway scheduler: runway lock record, grant class and FSM states.
package runway_scheduler_pkg;

  localparam int N_RUNWAYS = 2;
  localparam int ID_W      = 4;

  typedef struct packed {
    logic [ID_W-1:0] owner;
    logic            active;
  } runway_t;

  typedef enum logic {
    S_TAKEOFF = 1'b0,
    S_LANDING = 1'b1
  } sched_class_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } sched_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic first_set(input logic [N_RUNWAYS-1:0] v);
    logic idx;
    idx = 1'b0;
    for (int i = N_RUNWAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 1'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/runway_scheduler_slot.sv
// One runway lock: owner/active registers, release ID compare and, with RUNWAY_TIMEOUT_EN
// defined, an occupancy watchdog that frees the runway after TIMEOUT_CYCLES.
module runway_slot
  import runway_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            lock_i,
  input  logic [ID_W-1:0] lock_id_i,
  input  logic            free_i,
  input  logic [ID_W-1:0] release_id_i,
  output logic            active_o,
  output logic            match_o,
  output logic            timeout_o
);

  runway_t slot_q, slot_d;

  assign active_o = slot_q.active;
  assign match_o  = slot_q.active && (slot_q.owner == release_id_i);

`ifdef RUNWAY_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;
  logic             expire;

  // A release landing on the same edge takes priority over the watchdog.
  assign expire    = slot_q.active && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !free_i;
  assign timeout_o = timeout_q;

  always_comb begin
    cnt_d = cnt_q;
    if (lock_i)             cnt_d = '0;
    else if (slot_q.active) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end
`else
  logic expire;

  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    slot_d = slot_q;
    if (lock_i) begin
      slot_d.active = 1'b1;
      slot_d.owner  = lock_id_i;
    end else if (free_i || expire) begin
      slot_d.active = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

endmodule

// File: rtl/runway_scheduler.sv
// Runway scheduler: grants takeoff/landing queue heads onto free runways and offers CLEAR
// over valid/ready. Optional occupancy watchdog enabled by defining RUNWAY_TIMEOUT_EN.
module runway_scheduler
  import runway_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 takeoff_empty,
  input  logic [ID_W-1:0]      takeoff_id,
  output logic                 takeoff_pop,
  input  logic                 landing_empty,
  input  logic [ID_W-1:0]      landing_id,
  output logic                 landing_pop,
  input  logic                 emergency,
  input  logic                 release_valid,
  input  logic [ID_W-1:0]      release_id,
  output logic                 release_hit,
  output logic                 release_miss,
  output logic                 clr_valid,
  input  logic                 clr_ready,
  output logic [ID_W-1:0]      clr_id,
  output logic                 clr_runway,
  output logic                 clr_landing,
  output logic [N_RUNWAYS-1:0] runway_active,
  output logic [N_RUNWAYS-1:0] timeout_mask
);

  sched_state_t    state_q, state_d;
  logic            last_landing_q, last_landing_d;
  logic [ID_W-1:0] clr_id_q, clr_id_d;
  logic            clr_runway_q, clr_runway_d;
  logic            clr_landing_q, clr_landing_d;
  logic            hit_q, miss_q;

  logic [N_RUNWAYS-1:0] active, match, timeout, lock, free;
  logic                 landing_elig, takeoff_elig, grant, grant_runway;
  sched_class_t         grant_class;
  logic [ID_W-1:0]      grant_id;
  logic                 rel_any;

  assign landing_elig = !landing_empty;
  assign takeoff_elig = !takeoff_empty && !emergency;
  assign rel_any      = release_valid && (|match);

  always_comb begin
    free = '0;
    if (rel_any) free[first_set(match)] = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    last_landing_d = last_landing_q;
    clr_id_d       = clr_id_q;
    clr_runway_d   = clr_runway_q;
    clr_landing_d  = clr_landing_q;
    grant          = 1'b0;
    grant_class    = S_TAKEOFF;
    grant_runway   = first_set(~active);
    grant_id       = takeoff_id;
    lock           = '0;
    case (state_q)
      ST_IDLE: begin
        // Occupancy seen here is pre-release, so a runway freed this cycle waits one cycle.
        if (!(&active) && (landing_elig || takeoff_elig)) begin
          grant = 1'b1;
          if (landing_elig && (!takeoff_elig || !last_landing_q)) grant_class = S_LANDING;
          grant_id             = (grant_class == S_LANDING) ? landing_id : takeoff_id;
          lock[grant_runway]   = 1'b1;
          clr_id_d             = grant_id;
          clr_runway_d         = grant_runway;
          clr_landing_d        = (grant_class == S_LANDING);
          last_landing_d       = (grant_class == S_LANDING);
          state_d              = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (clr_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_landing_q <= 1'b0;
      clr_id_q       <= '0;
      clr_runway_q   <= 1'b0;
      clr_landing_q  <= 1'b0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_landing_q <= last_landing_d;
      clr_id_q       <= clr_id_d;
      clr_runway_q   <= clr_runway_d;
      clr_landing_q  <= clr_landing_d;
      hit_q          <= rel_any;
      miss_q         <= release_valid && !(|match);
    end
  end

  for (genvar i = 0; i < N_RUNWAYS; i++) begin : g_slot
    runway_slot #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .lock_i       (lock[i]),
      .lock_id_i    (grant_id),
      .free_i       (free[i]),
      .release_id_i (release_id),
      .active_o     (active[i]),
      .match_o      (match[i]),
      .timeout_o    (timeout[i])
    );
  end

  assign takeoff_pop   = grant && (grant_class == S_TAKEOFF) && !reset;
  assign landing_pop   = grant && (grant_class == S_LANDING) && !reset;
  assign clr_valid     = (state_q == ST_OFFER);
  assign clr_id        = clr_id_q;
  assign clr_runway    = clr_runway_q;
  assign clr_landing   = clr_landing_q;
  assign runway_active = active;
  assign timeout_mask  = timeout;
  assign release_hit   = hit_q;
  assign release_miss  = miss_q;

endmodule

// File: tb/tb_runway_scheduler.sv
// Bench for runway_scheduler: directed vector table, corner sequences and a randomized run
// against a cycle-level reference model. Watchdog checks apply when RUNWAY_TIMEOUT_EN is defined.
module tb_runway_scheduler;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       takeoff_empty, landing_empty, emergency, release_valid, clr_ready;
  logic [3:0] takeoff_id, landing_id, release_id;
  logic       takeoff_pop, landing_pop, release_hit, release_miss;
  logic       clr_valid, clr_runway, clr_landing;
  logic [3:0] clr_id;
  logic [1:0] runway_active, timeout_mask;

  int checks = 0;
  int errors = 0;

  runway_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .takeoff_empty(takeoff_empty), .takeoff_id(takeoff_id), .takeoff_pop(takeoff_pop),
    .landing_empty(landing_empty), .landing_id(landing_id), .landing_pop(landing_pop),
    .emergency(emergency), .release_valid(release_valid), .release_id(release_id),
    .release_hit(release_hit), .release_miss(release_miss),
    .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_id(clr_id),
    .clr_runway(clr_runway), .clr_landing(clr_landing),
    .runway_active(runway_active), .timeout_mask(timeout_mask)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 500000");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_in(input logic te, input logic [3:0] tid, input logic le, input logic [3:0] lid,
                        input logic em, input logic rv, input logic [3:0] rid, input logic rdy);
    takeoff_empty = te; takeoff_id = tid; landing_empty = le; landing_id = lid;
    emergency = em; release_valid = rv; release_id = rid; clr_ready = rdy;
  endtask

  // Reference model state
  logic       m_offer, m_last, m_hit, m_miss, m_rw, m_land;
  logic [3:0] m_id;
  logic       m_act[2];
  logic [3:0] m_own[2];
  logic [1:0] m_tmask;
  int         m_cnt[2];

  task automatic m_reset();
    m_offer = 0; m_last = 0; m_hit = 0; m_miss = 0; m_rw = 0; m_land = 0; m_id = 0; m_tmask = 0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_own[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    set_in(1, 0, 1, 0, 0, 0, 0, 1);
    reset = 1'b1;
    next_cyc();
    next_cyc();
    reset = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic te; logic [3:0] tid; logic le; logic [3:0] lid; logic em; logic rv; logic [3:0] rid; logic rdy;
    logic e_tpop; logic e_lpop; logic e_valid; logic [3:0] e_id; logic e_rw; logic e_land;
    logic [1:0] e_act; logic e_hit; logic e_miss;
  } vec_t;

  vec_t vt[9];

  initial begin
    reset = 1'b1;
    set_in(1, 0, 1, 0, 0, 0, 0, 1);

    // contested grants, full runways, release hit/miss, grant alongside release
    vt[0] = '{0, 9, 0, 3, 0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 2'b00, 0, 0};
    vt[1] = '{0, 9, 0, 4, 0, 0, 0, 1,  0, 0, 1, 3, 0, 1, 2'b01, 0, 0};
    vt[2] = '{0, 9, 0, 4, 0, 0, 0, 1,  1, 0, 0, 3, 0, 1, 2'b01, 0, 0};
    vt[3] = '{1, 0, 0, 4, 0, 0, 0, 1,  0, 0, 1, 9, 1, 0, 2'b11, 0, 0};
    vt[4] = '{1, 0, 0, 4, 0, 0, 0, 1,  0, 0, 0, 9, 1, 0, 2'b11, 0, 0};
    vt[5] = '{1, 0, 0, 4, 0, 1, 9, 1,  0, 0, 0, 9, 1, 0, 2'b11, 0, 0};
    vt[6] = '{1, 0, 0, 4, 0, 1, 4, 1,  0, 1, 0, 9, 1, 0, 2'b01, 1, 0};
    vt[7] = '{1, 0, 1, 0, 0, 0, 0, 1,  0, 0, 1, 4, 1, 1, 2'b11, 0, 1};
    vt[8] = '{1, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 4, 1, 1, 2'b11, 0, 0};

    do_reset();
    #1;
    chk("reset_clr_valid", clr_valid, 0);
    chk("reset_clr_id", clr_id, 0);
    chk("reset_clr_runway", clr_runway, 0);
    chk("reset_clr_landing", clr_landing, 0);
    chk("reset_active", runway_active, 0);
    chk("reset_hit", release_hit, 0);
    chk("reset_miss", release_miss, 0);
    chk("reset_tmask", timeout_mask, 0);
    chk("reset_pops", {takeoff_pop, landing_pop}, 0);

    // single landing grant: pop at N, offer at N+1
    set_in(1, 0, 0, 5, 0, 0, 0, 1);
    #1 chk("l5_pop", landing_pop, 1);
    next_cyc();
    set_in(1, 0, 1, 0, 0, 0, 0, 1);
    #1;
    chk("l5_valid", clr_valid, 1);
    chk("l5_id", clr_id, 5);
    chk("l5_runway", clr_runway, 0);
    chk("l5_landing", clr_landing, 1);
    chk("l5_active", runway_active, 2'b01);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].te, vt[i].tid, vt[i].le, vt[i].lid, vt[i].em, vt[i].rv, vt[i].rid, vt[i].rdy);
      #1;
      chk($sformatf("vec%0d_tpop", i), takeoff_pop, vt[i].e_tpop);
      chk($sformatf("vec%0d_lpop", i), landing_pop, vt[i].e_lpop);
      chk($sformatf("vec%0d_valid", i), clr_valid, vt[i].e_valid);
      chk($sformatf("vec%0d_id", i), clr_id, vt[i].e_id);
      chk($sformatf("vec%0d_runway", i), clr_runway, vt[i].e_rw);
      chk($sformatf("vec%0d_landing", i), clr_landing, vt[i].e_land);
      chk($sformatf("vec%0d_active", i), runway_active, vt[i].e_act);
      chk($sformatf("vec%0d_hit", i), release_hit, vt[i].e_hit);
      chk($sformatf("vec%0d_miss", i), release_miss, vt[i].e_miss);
      next_cyc();
    end

    // back-pressure: offer held while clr_ready is low
    do_reset();
    set_in(1, 0, 0, 6, 0, 0, 0, 1);
    #1 chk("hold_pop", landing_pop, 1);
    next_cyc();
    set_in(0, 8, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("hold_valid", clr_valid, 1);
      chk("hold_id", clr_id, 6);
      chk("hold_runway", clr_runway, 0);
      chk("hold_landing", clr_landing, 1);
      chk("hold_nopop", {takeoff_pop, landing_pop}, 0);
      next_cyc();
    end
    clr_ready = 1;
    #1 chk("hold_ready_valid", clr_valid, 1);
    chk("hold_ready_nopop", takeoff_pop, 0);
    next_cyc();
    #1 chk("resume_valid", clr_valid, 0);
    chk("resume_tpop", takeoff_pop, 1);
    next_cyc();
    #1 chk("resume_id", clr_id, 8);
    chk("resume_runway", clr_runway, 1);
    chk("resume_landing", clr_landing, 0);

    // reset in the middle of an offer drops it
    reset = 1'b1;
    #1 chk("midreset_valid", clr_valid, 0);
    chk("midreset_active", runway_active, 0);
    chk("midreset_pops", {takeoff_pop, landing_pop}, 0);
    next_cyc();
    reset = 1'b0;
    m_reset();

    // emergency blocks takeoffs only
    do_reset();
    set_in(0, 7, 1, 0, 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      #1 chk("emerg_nopop", {takeoff_pop, landing_pop}, 0);
      chk("emerg_novalid", clr_valid, 0);
      next_cyc();
    end
    landing_empty = 0; landing_id = 2;
    #1 chk("emerg_lpop", landing_pop, 1);
    chk("emerg_tpop", takeoff_pop, 0);
    next_cyc();
    #1 chk("emerg_id", clr_id, 2);
    chk("emerg_landing", clr_landing, 1);

`ifdef RUNWAY_TIMEOUT_EN
    // watchdog: runway 0 locked at edge L pulses after edge L+8, runway 1 two cycles later
    do_reset();
    set_in(1, 0, 0, 1, 0, 0, 0, 1);
    #1 chk("wd_pop0", landing_pop, 1);
    next_cyc();
    for (int k = 1; k <= 11; k++) begin
      landing_empty = !(k == 1 || k == 2 || k == 9);
      landing_id = (k == 9) ? 4'd3 : 4'd2;
      #1;
      if (k == 2) chk("wd_pop1", landing_pop, 1);
      if (k == 9) chk("wd_regrant_pop", landing_pop, 1);
      chk($sformatf("wd_tmask_k%0d", k), timeout_mask,
          (k == 9) ? 2'b01 : ((k == 11) ? 2'b10 : 2'b00));
      chk($sformatf("wd_active_k%0d", k), runway_active,
          (k <= 2) ? 2'b01 : ((k == 9) ? 2'b10 : ((k == 11) ? 2'b01 : 2'b11)));
      if (k == 10) begin
        chk("wd_regrant_id", clr_id, 3);
        chk("wd_regrant_runway", clr_runway, 0);
      end
      next_cyc();
    end
`else
    chk("no_wd_tmask", timeout_mask, 0);
`endif

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic land_ok, take_ok, do_grant, pick_land;
      int   tgt, rel_slot;
      takeoff_empty = ($urandom_range(0, 2) == 0);
      takeoff_id    = 4'($urandom_range(0, 15));
      landing_empty = ($urandom_range(0, 2) == 0);
      landing_id    = 4'($urandom_range(0, 15));
      emergency     = ($urandom_range(0, 7) == 0);
      release_valid = ($urandom_range(0, 3) == 0);
      release_id    = ($urandom_range(0, 1) == 1) ? m_own[$urandom_range(0, 1)] : 4'($urandom_range(0, 15));
      clr_ready     = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_valid", clr_valid, m_offer);
      chk("rnd_id", clr_id, m_id);
      chk("rnd_runway", clr_runway, m_rw);
      chk("rnd_landing", clr_landing, m_land);
      chk("rnd_active", runway_active, {m_act[1], m_act[0]});
      chk("rnd_hit", release_hit, m_hit);
      chk("rnd_miss", release_miss, m_miss);
      chk("rnd_tmask", timeout_mask, m_tmask);

      land_ok   = !landing_empty;
      take_ok   = !takeoff_empty && !emergency;
      do_grant  = !m_offer && !(m_act[0] && m_act[1]) && (land_ok || take_ok);
      pick_land = land_ok && (!take_ok || !m_last);
      tgt       = m_act[0] ? 1 : 0;
      chk("rnd_lpop", landing_pop, do_grant && pick_land);
      chk("rnd_tpop", takeoff_pop, do_grant && !pick_land);

      rel_slot = -1;
      for (int i = 0; i < 2; i++)
        if (rel_slot < 0 && release_valid && m_act[i] && m_own[i] == release_id) rel_slot = i;
      m_hit   = (rel_slot >= 0);
      m_miss  = release_valid && (rel_slot < 0);
      m_tmask = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (i == rel_slot) m_act[i] = 0;
`ifdef RUNWAY_TIMEOUT_EN
          else if (m_cnt[i] == TO - 1) begin
            m_act[i] = 0;
            m_tmask[i] = 1'b1;
          end
`endif
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (do_grant) begin
        m_act[tgt] = 1;
        m_own[tgt] = pick_land ? landing_id : takeoff_id;
        m_cnt[tgt] = 0;
        m_offer    = 1;
        m_id       = m_own[tgt];
        m_rw       = (tgt == 1);
        m_land     = pick_land;
        m_last     = pick_land;
      end else if (m_offer && clr_ready) begin
        m_offer = 0;
      end
      next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
